// File: rtl/id_stage_if.sv
// Signal bundle between the ID stage and its neighbours: IF/ID inputs, the
// write-back port, hazard-unit read addresses and the registered ID/EX outputs.
interface id_stage_if;
    logic        flush;
    logic        freeze;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic [3:0]  status;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;

    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;

    logic        ex_wb_en;
    logic        ex_mem_r;
    logic        ex_mem_w;
    logic        ex_b;
    logic        ex_s;
    logic [3:0]  ex_cmd;
    logic [31:0] ex_pc;
    logic [31:0] ex_val_rn;
    logic [31:0] ex_val_rm;
    logic        ex_imm;
    logic [11:0] ex_shift_op;
    logic [23:0] ex_imm24;
    logic [3:0]  ex_dest;
    logic [3:0]  ex_src1;
    logic [3:0]  ex_src2;

    modport slave (
        input  flush, freeze, instr, pc_in, status, wb_en, wb_dest, wb_value,
        output src1, src2, two_src,
        output ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s, ex_cmd, ex_pc,
               ex_val_rn, ex_val_rm, ex_imm, ex_shift_op, ex_imm24,
               ex_dest, ex_src1, ex_src2
    );

    modport master (
        output flush, freeze, instr, pc_in, status, wb_en, wb_dest, wb_value,
        input  src1, src2, two_src,
        input  ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s, ex_cmd, ex_pc,
               ex_val_rn, ex_val_rm, ex_imm, ex_shift_op, ex_imm24,
               ex_dest, ex_src1, ex_src2
    );
endinterface

// File: rtl/id_stage.sv
// ARM-subset instruction decode stage: control decode, condition check,
// 16x32 register file with write-through, and the ID/EX pipeline register.
module id_stage (
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);
    typedef struct packed {
        logic        wb_en;
        logic        mem_r;
        logic        mem_w;
        logic        b;
        logic        s;
        logic [3:0]  cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_op;
        logic [23:0] imm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } ex_t;

    logic [3:0]  cond;
    logic [1:0]  mode;
    logic        i_bit;
    logic [3:0]  opcode;
    logic        s_bit;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;

    assign cond   = bus.instr[31:28];
    assign mode   = bus.instr[27:26];
    assign i_bit  = bus.instr[25];
    assign opcode = bus.instr[24:21];
    assign s_bit  = bus.instr[20];
    assign rn     = bus.instr[19:16];
    assign rd     = bus.instr[15:12];
    assign rm     = bus.instr[3:0];

    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = bus.status;

    logic cond_pass;
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    logic [3:0] cmd_dec;
    logic       wb_dec, mem_r_dec, mem_w_dec, b_dec, s_dec;
    always_comb begin
        cmd_dec   = 4'b0000;
        wb_dec    = 1'b0;
        mem_r_dec = 1'b0;
        mem_w_dec = 1'b0;
        b_dec     = 1'b0;
        s_dec     = 1'b0;
        case (mode)
            2'b00: begin
                wb_dec = 1'b1;
                s_dec  = s_bit;
                case (opcode)
                    4'b1101: cmd_dec = 4'b0001;
                    4'b1111: cmd_dec = 4'b1001;
                    4'b0100: cmd_dec = 4'b0010;
                    4'b0101: cmd_dec = 4'b0011;
                    4'b0010: cmd_dec = 4'b0100;
                    4'b0110: cmd_dec = 4'b0101;
                    4'b0000: cmd_dec = 4'b0110;
                    4'b1100: cmd_dec = 4'b0111;
                    4'b0001: cmd_dec = 4'b1000;
                    4'b1010: begin cmd_dec = 4'b0100; wb_dec = 1'b0; end
                    4'b1000: begin cmd_dec = 4'b0110; wb_dec = 1'b0; end
                    default: begin wb_dec = 1'b0; s_dec = 1'b0; end
                endcase
            end
            2'b01: begin
                cmd_dec = 4'b0010;
                if (s_bit) begin
                    mem_r_dec = 1'b1;
                    wb_dec    = 1'b1;
                end else begin
                    mem_w_dec = 1'b1;
                end
            end
            2'b10: b_dec = 1'b1;
            default: ;
        endcase
    end

    // A store reads its data register (Rd) through the second port.
    logic is_str;
    assign is_str      = (mode == 2'b01) && !s_bit;
    assign bus.src1    = rn;
    assign bus.src2    = is_str ? rd : rm;
    assign bus.two_src = is_str || ((mode == 2'b00) && !i_bit);

    logic [31:0] rf_reg [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rf
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    rf_reg[gi] <= '0;
                else if (bus.wb_en && (bus.wb_dest == 4'(gi)))
                    rf_reg[gi] <= bus.wb_value;
            end
        end
    endgenerate

    // Write-through so a same-cycle write-back is seen without a stall.
    logic [31:0] val_rn_next, val_rm_next;
    assign val_rn_next = (bus.wb_en && bus.wb_dest == bus.src1) ? bus.wb_value : rf_reg[bus.src1];
    assign val_rm_next = (bus.wb_en && bus.wb_dest == bus.src2) ? bus.wb_value : rf_reg[bus.src2];

    logic ctrl_ok;
    assign ctrl_ok = cond_pass && !bus.freeze;

    ex_t ex_next, ex_reg;
    always_comb begin
        ex_next          = '0;
        ex_next.wb_en    = wb_dec & ctrl_ok;
        ex_next.mem_r    = mem_r_dec & ctrl_ok;
        ex_next.mem_w    = mem_w_dec & ctrl_ok;
        ex_next.b        = b_dec & ctrl_ok;
        ex_next.s        = s_dec & ctrl_ok;
        ex_next.cmd      = cmd_dec;
        ex_next.pc       = bus.pc_in;
        ex_next.val_rn   = val_rn_next;
        ex_next.val_rm   = val_rm_next;
        ex_next.imm      = i_bit;
        ex_next.shift_op = bus.instr[11:0];
        ex_next.imm24    = bus.instr[23:0];
        ex_next.dest     = rd;
        ex_next.src1     = bus.src1;
        ex_next.src2     = bus.src2;
    end

    // Flush wins over freeze: a squashed instruction leaves a full bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ex_reg <= '0;
        else if (bus.flush)
            ex_reg <= '0;
        else
            ex_reg <= ex_next;
    end

    assign bus.ex_wb_en    = ex_reg.wb_en;
    assign bus.ex_mem_r    = ex_reg.mem_r;
    assign bus.ex_mem_w    = ex_reg.mem_w;
    assign bus.ex_b        = ex_reg.b;
    assign bus.ex_s        = ex_reg.s;
    assign bus.ex_cmd      = ex_reg.cmd;
    assign bus.ex_pc       = ex_reg.pc;
    assign bus.ex_val_rn   = ex_reg.val_rn;
    assign bus.ex_val_rm   = ex_reg.val_rm;
    assign bus.ex_imm      = ex_reg.imm;
    assign bus.ex_shift_op = ex_reg.shift_op;
    assign bus.ex_imm24    = ex_reg.imm24;
    assign bus.ex_dest     = ex_reg.dest;
    assign bus.ex_src1     = ex_reg.src1;
    assign bus.ex_src2     = ex_reg.src2;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed instruction vectors, an instruction-level
// reference model checked every cycle, plus hand-computed literal checks.
module tb_id_stage;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    id_stage_if bus ();
    id_stage dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct packed {
        logic        wb_en;
        logic        mem_r;
        logic        mem_w;
        logic        b;
        logic        s;
        logic [3:0]  cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_op;
        logic [23:0] imm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } ex_t;

    logic [31:0] mregs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] st);
        bit n, z, cf, v;
        {n, z, cf, v} = st;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Architectural ALU command for a data-processing opcode; ok=0 if unsupported.
    function automatic logic [3:0] alu_cmd(input logic [3:0] opc, output bit ok);
        ok = 1'b1;
        case (opc)
            4'hD: return 4'd1;  // MOV
            4'hF: return 4'd9;  // MVN
            4'h4: return 4'd2;  // ADD
            4'h5: return 4'd3;  // ADC
            4'h2: return 4'd4;  // SUB
            4'h6: return 4'd5;  // SBC
            4'h0: return 4'd6;  // AND
            4'hC: return 4'd7;  // ORR
            4'h1: return 4'd8;  // EOR
            4'hA: return 4'd4;  // CMP
            4'h8: return 4'd6;  // TST
            default: begin ok = 1'b0; return 4'd0; end
        endcase
    endfunction

    function automatic logic [31:0] read_reg(input logic [3:0] a);
        if (bus.wb_en && bus.wb_dest == a) return bus.wb_value;
        return mregs[a];
    endfunction

    function automatic bit model_is_str(input logic [31:0] ins);
        return ins[27:26] == 2'b01 && !ins[20];
    endfunction

    function automatic logic [3:0] model_src2(input logic [31:0] ins);
        return model_is_str(ins) ? ins[15:12] : ins[3:0];
    endfunction

    function automatic bit model_two_src(input logic [31:0] ins);
        return model_is_str(ins) || (ins[27:26] == 2'b00 && !ins[25]);
    endfunction

    function automatic ex_t model_next();
        ex_t e;
        logic [31:0] ins;
        bit ok, go, cmp_or_tst;
        e = '0;
        if (bus.flush) return e;
        ins = bus.instr;
        go = cond_ok(ins[31:28], bus.status) && !bus.freeze;
        e.pc       = bus.pc_in;
        e.imm      = ins[25];
        e.shift_op = ins[11:0];
        e.imm24    = ins[23:0];
        e.dest     = ins[15:12];
        e.src1     = ins[19:16];
        e.src2     = model_src2(ins);
        e.val_rn   = read_reg(e.src1);
        e.val_rm   = read_reg(e.src2);
        case (ins[27:26])
            2'b00: begin
                e.cmd = alu_cmd(ins[24:21], ok);
                cmp_or_tst = (ins[24:21] == 4'hA) || (ins[24:21] == 4'h8);
                e.wb_en = go && ok && !cmp_or_tst;
                e.s     = go && ok && ins[20];
            end
            2'b01: begin
                e.cmd   = 4'd2;
                e.mem_r = go && ins[20];
                e.wb_en = go && ins[20];
                e.mem_w = go && !ins[20];
            end
            2'b10: e.b = go;
            default: ;
        endcase
        return e;
    endfunction

    function automatic ex_t dut_ex();
        ex_t a;
        a.wb_en = bus.ex_wb_en;   a.mem_r = bus.ex_mem_r;   a.mem_w = bus.ex_mem_w;
        a.b = bus.ex_b;           a.s = bus.ex_s;           a.cmd = bus.ex_cmd;
        a.pc = bus.ex_pc;         a.val_rn = bus.ex_val_rn; a.val_rm = bus.ex_val_rm;
        a.imm = bus.ex_imm;       a.shift_op = bus.ex_shift_op;
        a.imm24 = bus.ex_imm24;   a.dest = bus.ex_dest;
        a.src1 = bus.ex_src1;     a.src2 = bus.ex_src2;
        return a;
    endfunction

    // Per-edge reference: predict ID/EX contents, update model registers, compare.
    initial begin
        ex_t exp_ex, act_ex;
        for (int r = 0; r < 16; r++) mregs[r] = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_ex = '0;
                for (int r = 0; r < 16; r++) mregs[r] = '0;
            end else begin
                exp_ex = model_next();
                if (bus.wb_en) mregs[bus.wb_dest] = bus.wb_value;
            end
            #1;
            act_ex = dut_ex();
            checks++;
            if (act_ex !== exp_ex) begin
                errors++;
                $display("FAIL ex_bundle t=%0t actual=%h required=%h", $time, act_ex, exp_ex);
            end else begin
                $display("txn t=%0t instr=%h cmd=%h wb=%b mr=%b mw=%b b=%b s=%b pc=%h rn=%h rm=%h",
                         $time, bus.instr, act_ex.cmd, act_ex.wb_en, act_ex.mem_r, act_ex.mem_w,
                         act_ex.b, act_ex.s, act_ex.pc, act_ex.val_rn, act_ex.val_rm);
            end
        end
    end

    // Hazard-unit read addresses checked mid-cycle once inputs have settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("src1", {28'd0, bus.src1}, {28'd0, bus.instr[19:16]});
                chk("src2", {28'd0, bus.src2}, {28'd0, model_src2(bus.instr)});
                chk("two_src", {31'd0, bus.two_src}, {31'd0, model_two_src(bus.instr)});
            end
        end
    end

    task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] st,
                         input logic fl, input logic fz);
        @(negedge clk);
        bus.instr = ins; bus.pc_in = pc; bus.status = st;
        bus.flush = fl; bus.freeze = fz;
        bus.wb_en = 1'b0; bus.wb_dest = 4'd0; bus.wb_value = 32'd0;
    endtask

    task automatic set_wb(input logic en, input logic [3:0] dest, input logic [31:0] val);
        bus.wb_en = en; bus.wb_dest = dest; bus.wb_value = val;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] enc(input logic [3:0] c, input logic [1:0] m, input logic i,
                                        input logic [3:0] opc, input logic s, input logic [3:0] rn,
                                        input logic [3:0] rd, input logic [11:0] op2);
        return {c, m, i, opc, s, rn, rd, op2};
    endfunction

    localparam int NV = 24;
    logic [31:0] tbl_instr  [NV];
    logic [3:0]  tbl_status [NV];
    logic        tbl_flush  [NV];
    logic        tbl_freeze [NV];

    initial begin
        tbl_instr[0]  = enc(4'hE, 2'b00, 1'b1, 4'hF, 1'b0, 4'd0, 4'd2, 12'h0FF); tbl_status[0]  = 4'b0000;
        tbl_instr[1]  = enc(4'hC, 2'b00, 1'b0, 4'h2, 1'b1, 4'd1, 4'd3, 12'h002); tbl_status[1]  = 4'b0000;
        tbl_instr[2]  = enc(4'hC, 2'b00, 1'b0, 4'h2, 1'b1, 4'd1, 4'd3, 12'h002); tbl_status[2]  = 4'b0100;
        tbl_instr[3]  = enc(4'hD, 2'b00, 1'b0, 4'h6, 1'b0, 4'd5, 4'd6, 12'h007); tbl_status[3]  = 4'b1000;
        tbl_instr[4]  = enc(4'h8, 2'b00, 1'b0, 4'h0, 1'b0, 4'd2, 4'd7, 12'h008); tbl_status[4]  = 4'b0010;
        tbl_instr[5]  = enc(4'h8, 2'b00, 1'b0, 4'h0, 1'b0, 4'd2, 4'd7, 12'h008); tbl_status[5]  = 4'b0110;
        tbl_instr[6]  = enc(4'h9, 2'b00, 1'b1, 4'hC, 1'b0, 4'd3, 4'd8, 12'h0AB); tbl_status[6]  = 4'b0000;
        tbl_instr[7]  = enc(4'hE, 2'b00, 1'b0, 4'h1, 1'b1, 4'd4, 4'd9, 12'h00A); tbl_status[7]  = 4'b0000;
        tbl_instr[8]  = enc(4'hE, 2'b00, 1'b0, 4'hA, 1'b1, 4'd1, 4'd0, 12'h002); tbl_status[8]  = 4'b0000;
        tbl_instr[9]  = enc(4'hE, 2'b00, 1'b1, 4'h8, 1'b1, 4'd6, 4'd0, 12'h010); tbl_status[9]  = 4'b0000;
        tbl_instr[10] = enc(4'hF, 2'b00, 1'b1, 4'hD, 1'b0, 4'd0, 4'd1, 12'h001); tbl_status[10] = 4'b0000;
        tbl_instr[11] = enc(4'hE, 2'b11, 1'b0, 4'h4, 1'b1, 4'd2, 4'd3, 12'h004); tbl_status[11] = 4'b0000;
        tbl_instr[12] = enc(4'hE, 2'b00, 1'b1, 4'h3, 1'b1, 4'd2, 4'd3, 12'h004); tbl_status[12] = 4'b0000;
        tbl_instr[13] = enc(4'h0, 2'b00, 1'b0, 4'h4, 1'b0, 4'd7, 4'd8, 12'h009); tbl_status[13] = 4'b0100;
        tbl_instr[14] = enc(4'h2, 2'b00, 1'b1, 4'hD, 1'b0, 4'd0, 4'd9, 12'h033); tbl_status[14] = 4'b0010;
        tbl_instr[15] = enc(4'h3, 2'b00, 1'b1, 4'hD, 1'b0, 4'd0, 4'd9, 12'h033); tbl_status[15] = 4'b0010;
        tbl_instr[16] = enc(4'h4, 2'b00, 1'b0, 4'h5, 1'b0, 4'd10, 4'd11, 12'h00C); tbl_status[16] = 4'b0001;
        tbl_instr[17] = enc(4'h5, 2'b00, 1'b0, 4'h5, 1'b0, 4'd10, 4'd11, 12'h00C); tbl_status[17] = 4'b0001;
        tbl_instr[18] = enc(4'h6, 2'b01, 1'b0, 4'h4, 1'b1, 4'd12, 4'd13, 12'h004); tbl_status[18] = 4'b0001;
        tbl_instr[19] = enc(4'h7, 2'b01, 1'b0, 4'h4, 1'b0, 4'd12, 4'd13, 12'h004); tbl_status[19] = 4'b0001;
        tbl_instr[20] = enc(4'hA, 2'b10, 1'b1, 4'h5, 1'b0, 4'd1, 4'd2, 12'h345); tbl_status[20] = 4'b1001;
        tbl_instr[21] = enc(4'hB, 2'b10, 1'b1, 4'h5, 1'b0, 4'd1, 4'd2, 12'h345); tbl_status[21] = 4'b1001;
        tbl_instr[22] = enc(4'hE, 2'b01, 1'b0, 4'h4, 1'b0, 4'd14, 4'd15, 12'h000); tbl_status[22] = 4'b0000;
        tbl_instr[23] = enc(4'hE, 2'b00, 1'b0, 4'h4, 1'b1, 4'd15, 4'd14, 12'h00F); tbl_status[23] = 4'b0000;
        for (int k = 0; k < NV; k++) begin
            tbl_flush[k]  = (k % 7) == 3;
            tbl_freeze[k] = (k % 5) == 2;
        end
    end

    initial begin
        rst = 1'b1;
        bus.instr = '0; bus.pc_in = '0; bus.status = '0;
        bus.flush = 1'b0; bus.freeze = 1'b0;
        bus.wb_en = 1'b0; bus.wb_dest = '0; bus.wb_value = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex_wb_en", {31'd0, bus.ex_wb_en}, 32'd0);
        chk("reset_ex_pc", bus.ex_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Preload R0=7 under a no-op encoding
        apply(32'hEC000000, 32'd0, 4'b0000, 1'b0, 1'b0);
        set_wb(1'b1, 4'd0, 32'd7);
        edge_wait();

        apply(32'hE3A00014, 32'd4, 4'b0000, 1'b0, 1'b0);
        edge_wait();
        chk("mov_cmd", {28'd0, bus.ex_cmd}, 32'h1);
        chk("mov_wb_en", {31'd0, bus.ex_wb_en}, 32'd1);
        chk("mov_imm", {31'd0, bus.ex_imm}, 32'd1);
        chk("mov_dest", {28'd0, bus.ex_dest}, 32'd0);
        chk("mov_shift_op", {20'd0, bus.ex_shift_op}, 32'h014);

        apply(32'hE0A04004, 32'd8, 4'b0000, 1'b0, 1'b0);
        set_wb(1'b1, 4'd4, 32'd41);
        #2;
        chk("adc_src2", {28'd0, bus.src2}, 32'd4);
        chk("adc_two_src", {31'd0, bus.two_src}, 32'd1);
        edge_wait();
        chk("adc_bypass_rm", bus.ex_val_rm, 32'd41);
        chk("adc_val_rn", bus.ex_val_rn, 32'd7);
        chk("adc_cmd", {28'd0, bus.ex_cmd}, 32'h3);

        apply(32'h10811001, 32'd12, 4'b0100, 1'b0, 1'b0);
        edge_wait();
        chk("addne_fail_wb_en", {31'd0, bus.ex_wb_en}, 32'd0);
        chk("addne_cmd", {28'd0, bus.ex_cmd}, 32'h2);
        chk("addne_dest", {28'd0, bus.ex_dest}, 32'd1);
        apply(32'h10811001, 32'd16, 4'b0000, 1'b0, 1'b0);
        edge_wait();
        chk("addne_pass_wb_en", {31'd0, bus.ex_wb_en}, 32'd1);

        apply(32'hE4801000, 32'd20, 4'b0000, 1'b0, 1'b0);
        #2;
        chk("str_src2", {28'd0, bus.src2}, 32'd1);
        chk("str_two_src", {31'd0, bus.two_src}, 32'd1);
        edge_wait();
        chk("str_mem_w", {31'd0, bus.ex_mem_w}, 32'd1);
        chk("str_wb_en", {31'd0, bus.ex_wb_en}, 32'd0);
        apply(32'hE4901000, 32'd24, 4'b0000, 1'b0, 1'b0);
        edge_wait();
        chk("ldr_mem_r", {31'd0, bus.ex_mem_r}, 32'd1);
        chk("ldr_wb_en", {31'd0, bus.ex_wb_en}, 32'd1);

        apply(32'hBAFFFFF7, 32'd28, 4'b1000, 1'b0, 1'b0);
        edge_wait();
        chk("blt_b", {31'd0, bus.ex_b}, 32'd1);
        chk("blt_imm24", {8'd0, bus.ex_imm24}, 32'h00FFFFF7);
        apply(32'hBAFFFFF7, 32'd32, 4'b1000, 1'b1, 1'b1);
        edge_wait();
        chk("flush_b", {31'd0, bus.ex_b}, 32'd0);
        chk("flush_imm24", {8'd0, bus.ex_imm24}, 32'd0);
        chk("flush_pc", bus.ex_pc, 32'd0);
        apply(32'hBAFFFFF7, 32'd36, 4'b1000, 1'b0, 1'b1);
        edge_wait();
        chk("freeze_b", {31'd0, bus.ex_b}, 32'd0);
        chk("freeze_pc", bus.ex_pc, 32'd36);
        chk("freeze_imm24", {8'd0, bus.ex_imm24}, 32'h00FFFFF7);

        for (int k = 0; k < NV; k++) begin
            apply(tbl_instr[k], 32'(40 + 4 * k), tbl_status[k], tbl_flush[k], tbl_freeze[k]);
            if (k % 2 == 0) set_wb(1'b1, 4'(k % 16), $urandom);
            if (k % 6 == 1) set_wb(1'b1, tbl_instr[k][19:16], 32'hA5A50000 + 32'(k));
            edge_wait();
        end

        // Asynchronous reset between edges
        apply(32'hEC000000, 32'd96, 4'b0000, 1'b0, 1'b0);
        set_wb(1'b1, 4'd5, 32'hFFFFFF85);
        edge_wait();
        apply(32'hE1A00005, 32'd100, 4'b0000, 1'b0, 1'b0);
        edge_wait();
        chk("r5_before_reset", bus.ex_val_rm, 32'hFFFFFF85);
        chk("wb_before_reset", {31'd0, bus.ex_wb_en}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_wb_en", {31'd0, bus.ex_wb_en}, 32'd0);
        chk("async_rst_val_rm", bus.ex_val_rm, 32'd0);
        chk("async_rst_pc", bus.ex_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        edge_wait();
        chk("post_rst_r5", bus.ex_val_rm, 32'd0);
        chk("post_rst_pc", bus.ex_pc, 32'd100);
        chk("post_rst_wb_en", {31'd0, bus.ex_wb_en}, 32'd1);

        apply(32'hEC000000, 32'd104, 4'b0000, 1'b0, 1'b0);
        edge_wait();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 No parameters; fixed ARM-subset decode: 16 x 32-bit register file.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 flush  in  1  branch taken in EX; squash instruction in ID.
REQ-005 freeze  in  1  hazard stall; insert bubble into EX.
REQ-006 instr  in  32  instruction from IF/ID register.
REQ-007 pc_in  in  32  PC+4 of that instruction.
REQ-008 status  in  4  NZCV flags from status register ([3]=N,[2]=Z,[1]=C,[0]=V).
REQ-009 wb_en, wb_dest, wb_value  in  1/4/32  write-back port from WB stage.
REQ-010 src1, src2  out  4  combinational read addresses for hazard unit; two_src out 1 = src2 valid.
REQ-011 ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s  out  1 each  registered control to EX.
REQ-012 ex_cmd  out  4; ex_pc, ex_val_rn, ex_val_rm  out  32; ex_imm  out  1; ex_shift_op  out  12; ex_imm24  out  24; ex_dest, ex_src1, ex_src2  out  4; all registered.

Function
REQ-013 Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shift_op[11:0], Rm[3:0], imm24[23:0].
REQ-014 mode 00 data-processing: cmd MOV(1101)->0001, MVN(1111)->1001, ADD(0100)->0010, ADC(0101)->0011, SUB(0010)->0100, SBC(0110)->0101, AND(0000)->0110, ORR(1100)->0111, EOR(0001)->1000, CMP(1010)->0100, TST(1000)->0110; wb_en=1 except CMP/TST; s=S.
REQ-015 mode 01 memory: cmd 0010, S=1 -> LDR (mem_r=1, wb_en=1), S=0 -> STR (mem_w=1, wb_en=0); s=0.
REQ-016 mode 10 branch: b=1, all other control 0, cmd 0000; any other mode/opcode -> all control 0.
REQ-017 Condition pass: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0.
REQ-018 Control bits (wb_en, mem_r, mem_w, b, s) forced 0 when condition fails or freeze=1.
REQ-019 src1=Rn; src2=Rd for STR else Rm; two_src=1 for STR or data-processing with I=0, else 0.
REQ-020 Register file: two async read ports (src1, src2), one write port written at rising edge when wb_en=1.
REQ-021 Write-through: if wb_en=1 and wb_dest equals a read address in same cycle, that port returns wb_value.
REQ-022 ID/EX register updates every rising edge; latency one cycle from instr to ex_* outputs.
REQ-023 flush=1 at edge: every ex_* output loads 0 (full bubble); flush has priority over freeze.
REQ-024 freeze=1, flush=0: data fields load normally, control bits load 0 per REQ-018.
REQ-025 ex_dest=Rd, ex_src1=src1, ex_src2=src2, ex_imm=I, ex_pc=pc_in, ex_imm24=imm24 unmodified.

Reset
REQ-026 rst=1 immediately clears all ID/EX outputs and all 16 registers to 0, independent of clk.
REQ-027 Reset mid-instruction discards it; first post-reset edge captures current instr normally.

Verification
REQ-028 After reset, instr=0xE3A00014 (MOV R0,#20), status=0 -> next edge: ex_cmd=0001, ex_wb_en=1, ex_imm=1, ex_dest=0, ex_shift_op=0x014.
REQ-029 wb_en=1, wb_dest=4, wb_value=41, instr=0xE0A04000... use ADC R4,R0,R4 (0xE0A04004) same cycle -> ex_val_rm=41 (bypass), two_src=1, src2=4.
REQ-030 status=0100 (Z=1), instr=0x10811001 (ADDNE) -> ex_wb_en=0, ex_cmd=0010, ex_dest=1; status=0000 -> ex_wb_en=1.
REQ-031 instr=0xE4801000 (STR R1,[R0]) -> src2=1, two_src=1, ex_mem_w=1, ex_wb_en=0; 0xE4901000 -> ex_mem_r=1, ex_wb_en=1.
REQ-032 instr=0xBAFFFFF7, status N!=V -> ex_b=1, ex_imm24=0xFFFFF7; same with flush=1 -> all ex_* 0; with freeze=1 -> ex_b=0, ex_pc=pc_in.
REQ-033 Assert rst between edges while ex_wb_en=1 and R5=-123 -> outputs and R5 read 0 before next edge.
